// File: rtl/pixel_decryptor.sv
// Pixel keystream decryptor: three xorshift32 keystreams XORed onto incoming RGB pixels,
// valid/ready in and out, one output register stage, frame-length checker.
// Optional per-frame reseed on s_sof: define PIXEL_DECRYPTOR_SOF_RESEED_EN.
module pixel_decryptor #(
  parameter logic [31:0] SEED_R       = 32'd33,
  parameter logic [31:0] SEED_G       = 32'd63,
  parameter logic [31:0] SEED_B       = 32'd11,
  parameter int unsigned FRAME_PIXELS = 307200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_sof,
  input  logic [7:0]  s_r,
  input  logic [7:0]  s_g,
  input  logic [7:0]  s_b,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_sof,
  output logic [7:0]  m_r,
  output logic [7:0]  m_g,
  output logic [7:0]  m_b,
  output logic        frame_err,
  output logic [19:0] pix_cnt
);

  localparam logic [19:0] LP_FRAME = 20'(FRAME_PIXELS);

  // Handshake: a pixel moves on a clock edge where valid and ready are both high.
  // s_ready is combinational from the output register: free, or being drained this cycle.

  // Zero state would lock the generator, so it maps back to the channel seed.
  function automatic logic [31:0] f_next(input logic [31:0] s, input logic [31:0] seed);
    logic [31:0] a;
    logic [31:0] b;
    a = s ^ (s << 13);
    b = a ^ (a >> 7);
    f_next = (s == 32'd0) ? seed : (b ^ (b << 5));
  endfunction

  logic [31:0] r_sr, r_sg, r_sb;
  logic        r_m_valid, r_m_sof;
  logic [7:0]  r_m_r, r_m_g, r_m_b;
  logic        r_frame_err;
  logic [19:0] r_pix_cnt;

  logic        w_acc;
  logic        w_reseed;
  logic [31:0] w_use_r, w_use_g, w_use_b;

`ifdef PIXEL_DECRYPTOR_SOF_RESEED_EN
  assign w_reseed = s_sof;
`else
  assign w_reseed = 1'b0;
`endif

  assign s_ready = !r_m_valid || m_ready;
  assign w_acc   = s_valid && s_ready;

  always_comb begin
    w_use_r = r_sr;
    w_use_g = r_sg;
    w_use_b = r_sb;
    if (w_reseed) begin
      w_use_r = SEED_R;
      w_use_g = SEED_G;
      w_use_b = SEED_B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr <= SEED_R;
      r_sg <= SEED_G;
      r_sb <= SEED_B;
    end else if (w_acc) begin
      r_sr <= f_next(w_use_r, SEED_R);
      r_sg <= f_next(w_use_g, SEED_G);
      r_sb <= f_next(w_use_b, SEED_B);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_sof   <= 1'b0;
      r_m_r     <= 8'd0;
      r_m_g     <= 8'd0;
      r_m_b     <= 8'd0;
    end else if (w_acc) begin
      r_m_valid <= 1'b1;
      r_m_sof   <= s_sof;
      r_m_r     <= s_r ^ w_use_r[7:0];
      r_m_g     <= s_g ^ w_use_g[7:0];
      r_m_b     <= s_b ^ w_use_b[7:0];
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  // First sof after reset sees a zero count and never flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_cnt   <= 20'd0;
      r_frame_err <= 1'b0;
    end else if (w_acc) begin
      if (s_sof) begin
        if (r_pix_cnt != 20'd0 && r_pix_cnt != LP_FRAME) r_frame_err <= 1'b1;
        r_pix_cnt <= 20'd1;
      end else if (r_pix_cnt != 20'hFFFFF) begin
        r_pix_cnt <= r_pix_cnt + 20'd1;
      end
    end
  end

  assign m_valid   = r_m_valid;
  assign m_sof     = r_m_sof;
  assign m_r       = r_m_r;
  assign m_g       = r_m_g;
  assign m_b       = r_m_b;
  assign frame_err = r_frame_err;
  assign pix_cnt   = r_pix_cnt;

endmodule

// File: tb/tb_pixel_decryptor.sv
// Directed bench for pixel_decryptor (FRAME_PIXELS=4) with an expected-output queue.
// Inputs change 1 time unit after posedge; outputs are checked on the negedge.
module tb_pixel_decryptor;

  localparam logic [31:0] SEED_R = 32'd33;
  localparam logic [31:0] SEED_G = 32'd63;
  localparam logic [31:0] SEED_B = 32'd11;
  localparam int          FRAME  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_sof = 1'b0;
  logic [7:0]  s_r = 8'd0, s_g = 8'd0, s_b = 8'd0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_sof;
  logic [7:0]  m_r, m_g, m_b;
  logic        frame_err;
  logic [19:0] pix_cnt;

  int total = 0;
  int bad   = 0;

  logic [24:0] exp_q[$];
  logic [31:0] ms_r, ms_g, ms_b;
  logic [19:0] exp_cnt;
  logic        exp_err;

  pixel_decryptor #(.SEED_R(SEED_R), .SEED_G(SEED_G), .SEED_B(SEED_B), .FRAME_PIXELS(FRAME)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
    .s_r(s_r), .s_g(s_g), .s_b(s_b),
    .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof),
    .m_r(m_r), .m_g(m_g), .m_b(m_b),
    .frame_err(frame_err), .pix_cnt(pix_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] xs(input logic [31:0] s, input logic [31:0] seed);
    logic [31:0] a, b;
    if (s == 32'd0) return seed;
    a = s ^ (s << 13);
    b = a ^ (a >> 7);
    return b ^ (b << 5);
  endfunction

  function automatic logic [7:0] key_n(input logic [31:0] seed, input int n);
    logic [31:0] s;
    s = seed;
    for (int i = 0; i < n; i++) s = xs(s, seed);
    return s[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    ms_r = SEED_R; ms_g = SEED_G; ms_b = SEED_B;
    exp_cnt = 20'd0;
    exp_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic model_accept(input logic sof, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    logic [31:0] ur, ug, ub;
    ur = ms_r; ug = ms_g; ub = ms_b;
`ifdef PIXEL_DECRYPTOR_SOF_RESEED_EN
    if (sof) begin ur = SEED_R; ug = SEED_G; ub = SEED_B; end
`endif
    exp_q.push_back({sof, r ^ ur[7:0], g ^ ug[7:0], b ^ ub[7:0]});
    ms_r = xs(ur, SEED_R); ms_g = xs(ug, SEED_G); ms_b = xs(ub, SEED_B);
    if (sof) begin
      if (exp_cnt != 20'd0 && exp_cnt != 20'(FRAME)) exp_err = 1'b1;
      exp_cnt = 20'd1;
    end else if (exp_cnt != 20'hFFFFF) begin
      exp_cnt = exp_cnt + 20'd1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the pixel has been accepted.
  task automatic send(input logic sof, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bit done;
    done = 1'b0;
    s_valid = 1'b1; s_sof = sof; s_r = r; s_g = g; s_b = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (s_ready) begin
        model_accept(sof, r, g, b);
        done = 1'b1;
      end
      step();
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic send_rand(input logic sof);
    send(sof, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  // Scoreboard: every output transfer must match the oldest expected pixel.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        chk("pixel", {7'd0, m_sof, m_r, m_g, m_b}, {7'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic [7:0] hold_r;
    logic [19:0] hold_cnt;

    model_reset();
    step();
    do_reset();

    @(negedge clk);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_pix_cnt", {12'd0, pix_cnt}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_m_rgb", {8'd0, m_r, m_g, m_b}, 32'd0);
    step();

    // First three pixels, known keys.
    send(1'b1, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("p1_valid", {31'd0, m_valid}, 32'd1);
    chk("p1_sof", {31'd0, m_sof}, 32'd1);
    chk("p1_rgb", {8'd0, m_r, m_g, m_b}, 32'h00213F0B);
    step();
    send(1'b0, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("p2_rgb", {8'd0, m_r, m_g, m_b}, 32'h00411FAB);
    step();
    send(1'b0, 8'h41, 8'h1F, 8'hAB);
    @(negedge clk);
    chk("p3_rgb", {8'd0, m_r, m_g, m_b},
        {8'd0, 8'h41 ^ key_n(SEED_R, 2), 8'h1F ^ key_n(SEED_G, 2), 8'hAB ^ key_n(SEED_B, 2)});
    chk("p3_cnt", {12'd0, pix_cnt}, 32'd3);
    step();
    step();

    // Backpressure: held output, no acceptance, no key advance.
    m_ready = 1'b0;
    send_rand(1'b0);
    s_valid = 1'b1; s_sof = 1'b0; s_r = 8'h5A; s_g = 8'hC3; s_b = 8'h0F;
    @(negedge clk);
    hold_r = m_r;
    hold_cnt = pix_cnt;
    chk("bp_valid", {31'd0, m_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_s_ready", {31'd0, s_ready}, 32'd0);
      chk("bp_hold_r", {24'd0, m_r}, {24'd0, hold_r});
      chk("bp_cnt", {12'd0, pix_cnt}, {12'd0, hold_cnt});
    end
    step();
    m_ready = 1'b1;
    send(1'b0, 8'h5A, 8'hC3, 8'h0F);
    @(negedge clk);
    chk("bp_next_key", {8'd0, m_r, m_g, m_b},
        {8'd0, 8'h5A ^ key_n(SEED_R, 4), 8'hC3 ^ key_n(SEED_G, 4), 8'h0F ^ key_n(SEED_B, 4)});
    step();

    // Frame length checking with FRAME=4.
    do_reset();
    send_rand(1'b1);
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    send_rand(1'b1);
    @(negedge clk);
    chk("frame_ok_err", {31'd0, frame_err}, {31'd0, exp_err});
    chk("frame_ok_cnt", {12'd0, pix_cnt}, 32'd1);
    step();
    for (int i = 0; i < 2; i++) send_rand(1'b0);
    send_rand(1'b1);
    @(negedge clk);
    chk("frame_short_err", {31'd0, frame_err}, 32'd1);
    step();
    for (int i = 0; i < 6; i++) send_rand(1'b0);
    send_rand(1'b1);
    @(negedge clk);
    chk("frame_err_sticky", {31'd0, frame_err}, {31'd0, exp_err});
    chk("frame_cnt_model", {12'd0, pix_cnt}, {12'd0, exp_cnt});
    step();
    do_reset();
    @(negedge clk);
    chk("frame_err_cleared", {31'd0, frame_err}, 32'd0);
    step();

    // Sof after 10 pixels: reseed or continue.
    send(1'b1, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 9; i++) send_rand(1'b0);
    send(1'b1, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
`ifdef PIXEL_DECRYPTOR_SOF_RESEED_EN
    chk("reseed_key", {8'd0, m_r, m_g, m_b}, 32'h00213F0B);
`else
    chk("continue_key", {8'd0, m_r, m_g, m_b},
        {8'd0, key_n(SEED_R, 10), key_n(SEED_G, 10), key_n(SEED_B, 10)});
`endif
    step();

    // Reset mid-frame with a held output pixel.
    m_ready = 1'b0;
    send_rand(1'b0);
    @(negedge clk);
    chk("mid_held_valid", {31'd0, m_valid}, 32'd1);
    step();
    do_reset();
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_rst_cnt", {12'd0, pix_cnt}, 32'd0);
    step();
    m_ready = 1'b1;
    send(1'b0, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("mid_seed_key", {8'd0, m_r, m_g, m_b}, 32'h00213F0B);
    step();

    // Back-to-back random stream at full throughput.
    for (int i = 0; i < 20; i++) send_rand(i == 0);
    repeat (3) step();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_decryptor.md
Name: pixel_decryptor

Overview:
- Receiver-side counterpart of the pixel keystream encryptor.
- Regenerates the same three per-channel 32-bit xorshift keystreams and XORs them onto incoming encrypted RGB pixels to recover plaintext.
- Sits between the encrypted video source and the display/VGA pixel path.
- Uses a valid/ready handshake, a 1-stage output register, and a frame-length checker.

Parameters:
- SEED_R, 32'd33, reset/reseed value of red keystream state
- SEED_G, 32'd63, reset/reseed value of green keystream state
- SEED_B, 32'd11, reset/reseed value of blue keystream state
- FRAME_PIXELS, 307200, expected pixels per frame (640x480); range 1..2^20-1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- s_valid  in  1  encrypted pixel valid
- s_ready  out  1  block accepts pixel
- s_sof  in  1  first pixel of frame, qualified by s_valid
- s_r, s_g, s_b  in  8 each  encrypted channel bytes
- m_valid  out  1  decrypted pixel valid
- m_ready  in  1  downstream accepts
- m_sof  out  1  sof aligned with output pixel
- m_r, m_g, m_b  out  8 each  decrypted channel bytes
- frame_err  out  1  sticky: a frame length differed from FRAME_PIXELS
- pix_cnt  out  20  pixels accepted in current frame

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - State regs SR/SG/SB = SEED_R/G/B.
  - m_valid=0; m_sof=0; m_r/g/b=0.
  - pix_cnt=0; frame_err=0.
  - Reset mid-frame discards any held output pixel.
- Accept: acc = s_valid && s_ready; s_ready = !m_valid || m_ready (combinational).
- Key for an accepted pixel: channel state S in use, low byte S[7:0].
  - With reseed active (see Optional Feature), an s_sof pixel uses SEED_x instead of the current state.
- Next state:
  - a = S ^ (S<<13); b = a ^ (a>>7); next = b ^ (b<<5).
  - All 32-bit logical shifts; bits shifted out are dropped.
  - next(0) = SEED_x, so the all-zero lock-up state is never held.
  - On an sof reseed, the stored state becomes next(SEED_x).
- State advances only on acc; there is no advance on stall or idle.
- Output register loads on acc:
  - m_r = s_r ^ SR_key, same for g/b.
  - m_sof = s_sof; m_valid = 1.
  - Latency is 1 cycle from acceptance.
- If m_valid && m_ready && !s_valid: m_valid -> 0 next cycle. Data holds otherwise.
- Full throughput with m_ready=1: one pixel per clock.
- Frame counter:
  - On acc with s_sof=0: pix_cnt = pix_cnt+1, saturating at 2^20-1.
  - On acc with s_sof=1:
    - If pix_cnt != 0 and pix_cnt != FRAME_PIXELS, set frame_err.
    - Then pix_cnt = 1.
  - The first sof after reset (pix_cnt=0) never flags.
- frame_err clears only on rst.

Optional Feature:
- Macro: PIXEL_DECRYPTOR_SOF_RESEED_EN.
- Defined: the s_sof pixel reseeds all three channels as described, so encryptor and decryptor resynchronise every frame.
- Undefined:
  - s_sof has no effect on keystream.
  - State runs continuously from reset across frames.
  - s_sof is still used by the frame counter and m_sof.

Test Plan:
- Reset then one pixel, s_sof=1, s_r/g/b=0x00 -> next cycle m_valid=1, m_r/g/b = 0x21/0x3F/0x0B, m_sof=1.
- Second pixel, s_sof=0, inputs 0x00 -> m_r/g/b = 0x41/0x1F/0xAB. Third input 0x41/0x1F/0xAB (loopback of the encryptor's second key) -> output keyed with the third state (compare against a reference model); pix_cnt=3.
- Backpressure: hold m_ready=0 with s_valid=1 for 5 cycles -> s_ready=0, m_* stable, state not advanced. Release -> next output uses the next key in sequence, no skipped or repeated key.
- Frame length, FRAME_PIXELS=4:
  - sof frame of 4 pixels, then sof -> frame_err stays 0.
  - Frame of 3 pixels, then sof -> frame_err=1, held until rst.
- Reseed (macro defined): sof after 10 pixels -> key returns to 0x21/0x3F/0x0B. Macro undefined -> key continues the sequence (11th key).
- rst asserted mid-frame with m_valid=1 -> next cycle m_valid=0, pix_cnt=0, and the next pixel uses the seed keys.
